// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: datapath widths and the EX/WB word layout.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  // EX/WB word: {write enable, destination index, result data}
  localparam int EXWB_W      = 38;
  localparam int WB_WE_BIT   = 37;
  localparam int WB_DST_MSB  = 36;
  localparam int WB_DST_LSB  = 32;
  localparam int WB_DATA_MSB = 31;
  localparam int WB_DATA_LSB = 0;

endpackage

// File: rtl/regbank_read_port.sv
// One decode-stage read port: r0 forced to zero, write-first bypass of the
// word committing this cycle, otherwise the stored bank entry.
module regbank_read_port
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] bank_data,
  input  logic              commit,
  input  logic [ADDR_W-1:0] wr_dst,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data
);

  // Priority: hardwired zero, then same-cycle bypass, then storage.
  always_comb begin
    data = bank_data;
    if (addr == '0) begin
      data = '0;
    end else if (commit && (addr == wr_dst)) begin
      data = wr_data;
    end
  end

endmodule

// File: rtl/wb_regbank.sv
// Writeback stage and 32-entry architectural register bank with two
// bypassed read ports, an unbypassed debug port and a commit counter.
module wb_regbank
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [EXWB_W-1:0] wb_word,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [31:0]       wr_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Handshake: wb_valid marks wb_word as new for exactly one cycle. There is
  // no ready; the bank accepts every valid word. A stalled EX/WB register
  // holds wb_word with wb_valid low, so a held word never commits twice.

  logic [DATA_W-1:0] bank [DEPTH];
  logic [31:0]       wr_count_q;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_dst;
  logic [DATA_W-1:0] wr_data;
  logic              commit;

  assign wr_en   = wb_word[WB_WE_BIT];
  assign wr_dst  = wb_word[WB_DST_MSB:WB_DST_LSB];
  assign wr_data = wb_word[WB_DATA_MSB:WB_DATA_LSB];

  // r0 is never written; reset drops the word presented in its cycle.
  assign commit = wb_valid & wr_en & (wr_dst != '0) & ~reset;

  // Bank storage and commit counter; reset clears everything and wins over commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank[i] <= '0;
      end
      wr_count_q <= '0;
    end else if (commit) begin
      bank[wr_dst] <= wr_data;
      wr_count_q   <= wr_count_q + 32'd1;
    end
  end

  assign wr_count = wr_count_q;

  // Debug view sees only committed state, never the bypass.
  assign dbg_data = (dbg_addr == '0) ? '0 : bank[dbg_addr];

  regbank_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
    .addr      (rd_addr_a),
    .bank_data (bank[rd_addr_a]),
    .commit    (commit),
    .wr_dst    (wr_dst),
    .wr_data   (wr_data),
    .data      (rd_data_a)
  );

  regbank_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
    .addr      (rd_addr_b),
    .bank_data (bank[rd_addr_b]),
    .commit    (commit),
    .wr_dst    (wr_dst),
    .wr_data   (wr_data),
    .data      (rd_data_b)
  );

endmodule
